// File: rtl/ray_pkg.sv
// ============================================================================
// Package : ray_pkg
// Purpose : Shared types and constants for the ray unit: the 16-bit distance
//           type, the "no hit" distance, and the closest-hit sequencer states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ray_pkg;

    typedef logic [15:0] dist_t;

    localparam dist_t FAR_DIST = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/closest_hit_sequencer.sv
// ============================================================================
// Module  : closest_hit_sequencer
// Purpose : Per-ray scheduler for the sphere distance datapath. Takes one
//           candidate record per sphere (in index order), issues it to the
//           distance calculator with the running nearest distance as
//           OldDistance, tracks the nearest hit, and after NUM_SPHERES
//           candidates presents a single hit result over valid/ready.
// Ports   :
//   CLK, aresetn              clock, synchronous active-low reset
//   RayStart / RayBusy        begin a ray (IDLE only) / busy outside IDLE
//   Cand*                     candidate record in, CandValid/CandReady
//   Calc* (out)               registered record + OldDistance to calculator
//   CalcInputValid/Ready      issue handshake to calculator
//   CalcOutputReady, CalcIntersects, CalcDistance
//                             one-cycle calculator result strobe
//   HitValid/HitReady         result handshake to shading stage
//   Hit, HitDistance, HitIndex
//                             nearest-hit result, registered
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module closest_hit_sequencer
    import ray_pkg::*;
#(
    parameter int    NUM_SPHERES = 8,
    parameter int    IDX_W       = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1,
    parameter dist_t FAR_DIST    = ray_pkg::FAR_DIST
) (
    input  logic               CLK,
    input  logic               aresetn,

    input  logic               RayStart,
    output logic               RayBusy,

    input  logic               CandValid,
    output logic               CandReady,
    input  logic [15:0]        CandRootDisc,
    input  logic [15:0]        CandB,
    input  logic               CandQuick,

    output logic [15:0]        CalcRootDiscriminant,
    output logic [15:0]        CalcB,
    output logic               CalcQuickIntersects,
    output logic [15:0]        CalcOldDistance,
    output logic               CalcInputValid,
    input  logic               CalcInputReady,
    input  logic               CalcOutputReady,
    input  logic               CalcIntersects,
    input  logic [15:0]        CalcDistance,

    output logic               HitValid,
    input  logic               HitReady,
    output logic               Hit,
    output logic [15:0]        HitDistance,
    output logic [IDX_W-1:0]   HitIndex
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPHERES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    seq_state_t         state_q,      state_d;
    logic [IDX_W-1:0]   count_q,      count_d;
    dist_t              best_q,       best_d;
    logic [IDX_W-1:0]   best_idx_q,   best_idx_d;
    logic               hit_q,        hit_d;

    logic [15:0]        calc_rd_q,    calc_rd_d;
    logic [15:0]        calc_b_q,     calc_b_d;
    logic               calc_quick_q, calc_quick_d;

    // Result registers are separate from the running best so the result
    // outputs read zero outside DONE and stay frozen during the handshake.
    logic               res_hit_q,    res_hit_d;
    dist_t              res_dist_q,   res_dist_d;
    logic [IDX_W-1:0]   res_idx_q,    res_idx_d;

    always_ff @(posedge CLK) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            best_q       <= FAR_DIST;
            best_idx_q   <= '0;
            hit_q        <= 1'b0;
            calc_rd_q    <= '0;
            calc_b_q     <= '0;
            calc_quick_q <= 1'b0;
            res_hit_q    <= 1'b0;
            res_dist_q   <= '0;
            res_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            best_q       <= best_d;
            best_idx_q   <= best_idx_d;
            hit_q        <= hit_d;
            calc_rd_q    <= calc_rd_d;
            calc_b_q     <= calc_b_d;
            calc_quick_q <= calc_quick_d;
            res_hit_q    <= res_hit_d;
            res_dist_q   <= res_dist_d;
            res_idx_q    <= res_idx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        best_d       = best_q;
        best_idx_d   = best_idx_q;
        hit_d        = hit_q;
        calc_rd_d    = calc_rd_q;
        calc_b_d     = calc_b_q;
        calc_quick_d = calc_quick_q;
        res_hit_d    = res_hit_q;
        res_dist_d   = res_dist_q;
        res_idx_d    = res_idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (RayStart) begin
                    best_d     = FAR_DIST;
                    hit_d      = 1'b0;
                    best_idx_d = '0;
                    count_d    = '0;
                    state_d    = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (CandValid) begin
                    calc_rd_d    = CandRootDisc;
                    calc_b_d     = CandB;
                    calc_quick_d = CandQuick;
                    state_d      = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (CalcInputReady) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // The calculator already rejects t >= OldDistance, so a
                // reported intersection is always a strict improvement.
                if (CalcOutputReady) begin
                    if (CalcIntersects) begin
                        best_d     = CalcDistance;
                        best_idx_d = count_q;
                        hit_d      = 1'b1;
                    end
                    if (count_q == LAST_IDX) begin
                        res_hit_d  = hit_d;
                        res_dist_d = best_d;
                        res_idx_d  = best_idx_d;
                        state_d    = ST_DONE;
                    end else begin
                        count_d = count_q + IDX_ONE;
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_DONE: begin
                if (HitReady) begin
                    res_hit_d  = 1'b0;
                    res_dist_d = '0;
                    res_idx_d  = '0;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign RayBusy              = (state_q != ST_IDLE);
    assign CandReady            = (state_q == ST_FETCH);
    assign CalcInputValid       = (state_q == ST_ISSUE);
    assign HitValid             = (state_q == ST_DONE);

    assign CalcRootDiscriminant = calc_rd_q;
    assign CalcB                = calc_b_q;
    assign CalcQuickIntersects  = calc_quick_q;
    assign CalcOldDistance      = best_q;

    assign Hit                  = res_hit_q;
    assign HitDistance          = res_dist_q;
    assign HitIndex             = res_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_closest_hit_sequencer.sv
// ============================================================================
// Module  : tb_closest_hit_sequencer
// Purpose : Self-checking bench for closest_hit_sequencer with NUM_SPHERES=3.
//           Directed rays from the test plan plus randomized rays, checked
//           against a reference that picks the nearest qualifying distance.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_closest_hit_sequencer;

    localparam int NS = 3;
    localparam int IW = 2;

    logic          CLK = 1'b0;
    logic          aresetn;
    logic          RayStart;
    logic          RayBusy;
    logic          CandValid;
    logic          CandReady;
    logic [15:0]   CandRootDisc;
    logic [15:0]   CandB;
    logic          CandQuick;
    logic [15:0]   CalcRootDiscriminant;
    logic [15:0]   CalcB;
    logic          CalcQuickIntersects;
    logic [15:0]   CalcOldDistance;
    logic          CalcInputValid;
    logic          CalcInputReady;
    logic          CalcOutputReady;
    logic          CalcIntersects;
    logic [15:0]   CalcDistance;
    logic          HitValid;
    logic          HitReady;
    logic          Hit;
    logic [15:0]   HitDistance;
    logic [IW-1:0] HitIndex;

    closest_hit_sequencer #(.NUM_SPHERES(NS)) dut (
        .CLK                 (CLK),
        .aresetn             (aresetn),
        .RayStart            (RayStart),
        .RayBusy             (RayBusy),
        .CandValid           (CandValid),
        .CandReady           (CandReady),
        .CandRootDisc        (CandRootDisc),
        .CandB               (CandB),
        .CandQuick           (CandQuick),
        .CalcRootDiscriminant(CalcRootDiscriminant),
        .CalcB               (CalcB),
        .CalcQuickIntersects (CalcQuickIntersects),
        .CalcOldDistance     (CalcOldDistance),
        .CalcInputValid      (CalcInputValid),
        .CalcInputReady      (CalcInputReady),
        .CalcOutputReady     (CalcOutputReady),
        .CalcIntersects      (CalcIntersects),
        .CalcDistance        (CalcDistance),
        .HitValid            (HitValid),
        .HitReady            (HitReady),
        .Hit                 (Hit),
        .HitDistance         (HitDistance),
        .HitIndex            (HitIndex)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Candidate table for the current ray
    logic [15:0] c_rd [NS];
    logic [15:0] c_b  [NS];
    logic        c_q  [NS];

    // Environment state shared between driver processes and main thread
    int          cand_idx  = NS;
    int          xfers     = 0;
    int          g_at      = -1;
    int          g_left    = 0;
    int          issue_idx = 0;
    bit          stall_en  = 1'b0;
    logic [15:0] run_best  = 16'hFFFF;

    function automatic int t_of(input logic [15:0] b, input logic [15:0] rd);
        return (-int'($signed(b)) - int'(rd)) / 2;
    endfunction

    // Candidate source: offers cand[cand_idx], with an optional gap held
    // only while the sequencer is asking for a candidate.
    initial begin
        CandValid = 1'b0; CandRootDisc = '0; CandB = '0; CandQuick = 1'b0;
        forever begin
            @(negedge CLK); #1;
            if (cand_idx < NS) begin
                CandRootDisc = c_rd[cand_idx];
                CandB        = c_b[cand_idx];
                CandQuick    = c_q[cand_idx];
                CandValid    = 1'b1;
            end else begin
                CandRootDisc = 16'($urandom);
                CandB        = 16'($urandom);
                CandQuick    = 1'($urandom);
                CandValid    = 1'b0;
            end
            if (CandReady && cand_idx == g_at && g_left > 0) begin
                CandValid = 1'b0;
                g_left--;
            end
            if (aresetn && CandValid && CandReady) begin
                cand_idx++;
                xfers++;
            end
        end
    end

    // Distance calculator model: result strobe two cycles after transfer,
    // rejects t >= OldDistance, random distance on miss and when idle.
    initial begin
        int          pend;
        logic        p_hit;
        logic [15:0] p_dist;
        int          t;
        pend = 0; p_hit = 1'b0; p_dist = '0;
        CalcInputReady = 1'b1; CalcOutputReady = 1'b0;
        CalcIntersects = 1'b0; CalcDistance = '0;
        forever begin
            @(negedge CLK); #1;
            CalcOutputReady = 1'b0;
            CalcIntersects  = 1'($urandom);
            CalcDistance    = 16'($urandom);
            if (!aresetn) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        CalcOutputReady = 1'b1;
                        CalcIntersects  = p_hit;
                        CalcDistance    = p_dist;
                        if (p_hit) run_best = p_dist;
                    end
                end
                CalcInputReady = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (CalcInputValid && CalcInputReady) begin
                    if (issue_idx < NS) begin
                        check_eq("calc_rd",    32'(CalcRootDiscriminant), 32'(c_rd[issue_idx]));
                        check_eq("calc_b",     32'(CalcB),                32'(c_b[issue_idx]));
                        check_eq("calc_quick", 32'(CalcQuickIntersects),  32'(c_q[issue_idx]));
                        check_eq("calc_old",   32'(CalcOldDistance),      32'(run_best));
                    end else begin
                        check_eq("extra_issue", 32'(issue_idx), 32'(NS - 1));
                    end
                    t = t_of(CalcB, CalcRootDiscriminant);
                    p_hit  = CalcQuickIntersects && (t >= 0) && (t < int'(CalcOldDistance));
                    p_dist = p_hit ? 16'(t) : 16'($urandom);
                    pend   = 2;
                    issue_idx++;
                end
            end
        end
    end

    task automatic set_cand(input int i, input int t, input int rd, input bit q);
        c_rd[i] = 16'(rd);
        c_b[i]  = 16'(-(2 * t + rd));
        c_q[i]  = q;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"},  32'(RayBusy),              32'd0);
        check_eq({tag, "_cready"},32'(CandReady),            32'd0);
        check_eq({tag, "_ivalid"},32'(CalcInputValid),       32'd0);
        check_eq({tag, "_hvalid"},32'(HitValid),             32'd0);
        check_eq({tag, "_hit"},   32'(Hit),                  32'd0);
        check_eq({tag, "_hdist"}, 32'(HitDistance),          32'd0);
        check_eq({tag, "_hidx"},  32'(HitIndex),             32'd0);
        check_eq({tag, "_old"},   32'(CalcOldDistance),      32'hFFFF);
        check_eq({tag, "_crd"},   32'(CalcRootDiscriminant), 32'd0);
        check_eq({tag, "_cb"},    32'(CalcB),                32'd0);
        check_eq({tag, "_cq"},    32'(CalcQuickIntersects),  32'd0);
    endtask

    task automatic start_ray(output int start_cyc);
        cand_idx  = 0;
        xfers     = 0;
        issue_idx = 0;
        run_best  = 16'hFFFF;
        @(negedge CLK);
        RayStart  = 1'b1;
        start_cyc = cyc;
        @(negedge CLK);
        RayStart  = 1'b0;
    endtask

    task automatic run_ray(input string tag, input int gap_at, input int gap_len,
                           input int hr_delay, input bit stall,
                           input bit pulse_wait, input bit pulse_done);
        int          start_cyc;
        int          budget;
        bit          pulsed;
        int          t;
        int          best_t;
        logic        ehit;
        logic [15:0] ed;
        logic [IW-1:0] ei;

        // Nearest qualifying distance; on ties the lowest index.
        best_t = 32'h7FFF_FFFF;
        for (int i = 0; i < NS; i++) begin
            t = t_of(c_b[i], c_rd[i]);
            if (c_q[i] && t >= 0 && t < 'hFFFF && t < best_t) best_t = t;
        end
        ehit = (best_t != 32'h7FFF_FFFF);
        ed   = ehit ? 16'(best_t) : 16'hFFFF;
        ei   = '0;
        if (ehit) begin
            for (int i = NS - 1; i >= 0; i--) begin
                t = t_of(c_b[i], c_rd[i]);
                if (c_q[i] && t == best_t) ei = IW'(i);
            end
        end

        g_at     = gap_at;
        g_left   = gap_len;
        stall_en = stall;
        start_ray(start_cyc);

        budget = 0;
        pulsed = 1'b0;
        while (!HitValid && budget < 2000) begin
            if (pulse_wait && !pulsed && RayBusy && !CandReady && !CalcInputValid) begin
                RayStart = 1'b1;
                pulsed   = 1'b1;
            end else begin
                RayStart = 1'b0;
            end
            @(negedge CLK);
            budget++;
        end
        RayStart = 1'b0;

        check_eq({tag, "_hvalid"}, 32'(HitValid), 32'd1);
        if (!HitValid) return;
        if (!stall) check_eq({tag, "_latency"}, 32'(cyc - start_cyc), 32'(4 * NS + 1 + gap_len));
        if (pulse_wait) check_eq({tag, "_pulsed"}, 32'(pulsed), 32'd1);
        check_eq({tag, "_xfers"}, 32'(xfers), 32'(NS));
        check_eq({tag, "_hit"},   32'(Hit),          32'(ehit));
        check_eq({tag, "_dist"},  32'(HitDistance),  32'(ed));
        check_eq({tag, "_idx"},   32'(HitIndex),     32'(ei));

        for (int k = 0; k < hr_delay; k++) begin
            @(negedge CLK);
            check_eq({tag, "_hold_valid"}, 32'(HitValid),    32'd1);
            check_eq({tag, "_hold_hit"},   32'(Hit),         32'(ehit));
            check_eq({tag, "_hold_dist"},  32'(HitDistance), 32'(ed));
            check_eq({tag, "_hold_idx"},   32'(HitIndex),    32'(ei));
        end

        HitReady = 1'b1;
        if (pulse_done) RayStart = 1'b1;
        @(negedge CLK);
        HitReady = 1'b0;
        RayStart = 1'b0;
        check_eq({tag, "_idle_busy"},   32'(RayBusy),  32'd0);
        check_eq({tag, "_idle_hvalid"}, 32'(HitValid), 32'd0);
        if (pulse_done) begin
            @(negedge CLK);
            check_eq({tag, "_no_restart"}, 32'(RayBusy), 32'd0);
        end
    endtask

    initial begin
        int s;
        int budget;
        int t;
        aresetn  = 1'b0;
        RayStart = 1'b0;
        HitReady = 1'b0;
        repeat (3) @(negedge CLK);
        aresetn = 1'b1;
        check_reset_outputs("reset");

        // Nearest is sphere 1 (8); sphere 2 (50) is rejected
        set_cand(0, 10, 20, 1'b1);
        set_cand(1, 8,  4,  1'b1);
        set_cand(2, 50, 0,  1'b1);
        run_ray("basic", -1, 0, 0, 1'b0, 1'b0, 1'b0);

        // All quick flags low: no hit, best stays far
        set_cand(0, 10, 20, 1'b0);
        set_cand(1, 8,  4,  1'b0);
        set_cand(2, 3,  6,  1'b0);
        run_ray("miss", -1, 0, 2, 1'b0, 1'b0, 1'b0);

        // Equal distances: lowest index wins
        set_cand(0, 12, 0, 1'b1);
        set_cand(1, 20, 8, 1'b1);
        set_cand(2, 12, 2, 1'b1);
        run_ray("tie", -1, 0, 0, 1'b0, 1'b0, 1'b0);

        // Candidate gap of 5 cycles in FETCH of sphere 1
        set_cand(0, 30, 10, 1'b1);
        set_cand(1, 40, 2,  1'b1);
        set_cand(2, 7,  9,  1'b1);
        run_ray("gap", 1, 5, 0, 1'b0, 1'b0, 1'b0);

        // Result held 7 cycles under HitReady low
        run_ray("hold", -1, 0, 7, 1'b0, 1'b0, 1'b0);

        // RayStart pulsed in WAIT and in the DONE handshake cycle
        set_cand(0, 100, 0, 1'b1);
        set_cand(1, 5,   0, 1'b0);
        set_cand(2, 60,  1, 1'b1);
        run_ray("rs_ignore", -1, 0, 1, 1'b0, 1'b1, 1'b1);
        run_ray("second_ray", -1, 0, 0, 1'b0, 1'b0, 1'b0);

        // Reset during WAIT of sphere 1 aborts the ray
        g_at = -1; g_left = 0; stall_en = 1'b0;
        start_ray(s);
        budget = 0;
        while (!(xfers == 2 && RayBusy && !CandReady && !CalcInputValid) && budget < 100) begin
            @(negedge CLK);
            budget++;
        end
        check_eq("midrst_reach_wait", 32'(budget < 100), 32'd1);
        aresetn = 1'b0;
        @(negedge CLK);
        aresetn = 1'b1;
        check_reset_outputs("midrst");
        @(negedge CLK);
        check_eq("midrst_stay_idle", 32'(RayBusy), 32'd0);
        set_cand(0, 25, 3, 1'b1);
        set_cand(1, 9,  1, 1'b1);
        set_cand(2, 9,  5, 1'b1);
        run_ray("after_rst", -1, 0, 0, 1'b0, 1'b0, 1'b0);

        // Randomized rays
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < NS; i++) begin
                t = (i > 0 && $urandom_range(0, 3) == 0) ? t_of(c_b[0], c_rd[0])
                                                         : int'($urandom_range(0, 3000));
                set_cand(i, t, int'($urandom_range(0, 1000)), ($urandom_range(0, 3) != 0));
            end
            run_ray("rand", int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'($urandom), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
